quadrature_emitter: RTL and testbench



---
 rtl/quadrature_emitter_if.sv | 10 +
 rtl/quadrature_emitter.sv | 94 +++++++++
 tb/tb_quadrature_emitter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/quadrature_emitter_if.sv
// quadrature_emitter_if: command handshake and abort request for the quadrature emitter
interface quadrature_emitter_if #(parameter int COUNT_W = 8);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [COUNT_W-1:0] cmd_count;
  logic               abort;
  modport master (output cmd_valid, cmd_dir, cmd_count, abort, input cmd_ready);
  modport slave (input cmd_valid, cmd_dir, cmd_count, abort, output cmd_ready);
endinterface

// File: rtl/quadrature_emitter.sv
// quadrature_emitter: drives encA/encB like a rotary encoder turned a commanded number of detents
module quadrature_emitter #(
  parameter int PHASE_CYCLES = 16,
  parameter int COUNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  quadrature_emitter_if.slave  bus,
  output logic                 encA,
  output logic                 encB,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             r_state;
  logic               r_dir;
  logic               r_abort_pend;
  logic               r_enc_a;
  logic               r_enc_b;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [COUNT_W-1:0] r_remaining;
  logic [1:0]         r_phase;
  logic [15:0]        r_dwell;
  logic [1:0]         w_next_phase;
  logic               w_expire;
  logic               w_last;
  // Up walks 01,11,10,00; down is the same walk with A and B swapped.
  function automatic logic [1:0] ab_of(input logic dir, input logic [1:0] ph);
    return dir ? {ph[1] ^ ph[0], ~ph[1]} : {~ph[1], ph[1] ^ ph[0]};
  endfunction
  assign w_next_phase  = r_phase + 2'd1;
  assign w_expire      = en && (r_dwell == 16'(PHASE_CYCLES - 1));
  assign w_last        = r_phase == 2'd3;
  assign encA          = r_enc_a;
  assign encB          = r_enc_b;
  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.cmd_ready = r_ready;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_dir        <= 1'b0;
      r_enc_a      <= 1'b0;
      r_enc_b      <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_remaining  <= '0;
      r_phase      <= '0;
      r_dwell      <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.cmd_valid && r_ready) begin
          if (bus.cmd_count == '0) begin
            r_done <= 1'b1;
          end else begin
            r_state              <= RUN;
            r_dir                <= bus.cmd_dir;
            r_remaining          <= bus.cmd_count;
            r_phase              <= 2'd0;
            r_dwell              <= '0;
            {r_enc_a, r_enc_b}   <= ab_of(bus.cmd_dir, 2'd0);
            r_ready              <= 1'b0;
            r_busy               <= 1'b1;
          end
        end
      end else begin
        if (bus.abort) r_abort_pend <= 1'b1;
        if (en) r_dwell <= w_expire ? '0 : r_dwell + 16'd1;
        if (w_expire) begin
          r_phase            <= w_next_phase;
          {r_enc_a, r_enc_b} <= ab_of(r_dir, w_next_phase);
          // Exit is decided before reload, so remaining never wraps below one.
          if (w_last) begin
            r_remaining <= r_remaining - COUNT_W'(1);
            if (r_remaining == COUNT_W'(1) || r_abort_pend) begin
              r_state            <= IDLE;
              {r_enc_a, r_enc_b} <= 2'b00;
              r_ready            <= 1'b1;
              r_busy             <= 1'b0;
              r_done             <= 1'b1;
              r_abort_pend       <= 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_quadrature_emitter.sv
// tb_quadrature_emitter: randomized and directed checks of the quadrature emitter against a tick-count model
module tb_quadrature_emitter;
  localparam int P  = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;
  logic en1 = 1'b1;
  logic enc_a, enc_b, busy, done;
  logic enc_a1, enc_b1, busy1, done1;
  int n_chk = 0;
  int n_pass = 0;
  logic [3:0] tr_obs[$];
  int tr_t[$];
  int res_edges, res_dec, res_glitch, res_busy, res_dones, res_ready_low, res_abort_t;
  quadrature_emitter_if #(.COUNT_W(CW)) bus ();
  quadrature_emitter_if #(.COUNT_W(CW)) bus1 ();
  quadrature_emitter #(.PHASE_CYCLES(P), .COUNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .encA(enc_a), .encB(enc_b), .busy(busy), .done(done)
  );
  quadrature_emitter #(.PHASE_CYCLES(1), .COUNT_W(CW)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .bus(bus1),
    .encA(enc_a1), .encB(enc_b1), .busy(busy1), .done(done1)
  );
  always #5 clk = ~clk;
  // Expected {busy,done,A,B} after t en-ticks of an n-detent command.
  function automatic logic [3:0] model_obs(input logic dir, input int t, input int n);
    int k = (t / P) % 4;
    logic [1:0] ab;
    if (t > 4 * n * P) return 4'b0000;
    if (t == 4 * n * P) return 4'b0100;
    ab = (k == 0) ? 2'b01 : (k == 1) ? 2'b11 : (k == 2) ? 2'b10 : 2'b00;
    return {2'b10, dir ? ab : {ab[0], ab[1]}};
  endfunction
  // Issues one command from a negedge and records the response until done or maxc samples.
  task automatic run(input logic dir, input int n, input int en_per, input int abort_k, input int maxc);
    int t = 0;
    logic [1:0] prev = {enc_a, enc_b};
    tr_obs.delete();
    tr_t.delete();
    res_edges = 0; res_dec = 0; res_glitch = 0; res_busy = 0; res_dones = 0; res_ready_low = 0; res_abort_t = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dir = dir;
    bus.cmd_count = CW'(n);
    bus.abort = (abort_k == -2);
    en = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.abort = 1'b0;
      tr_obs.push_back({busy, done, enc_a, enc_b});
      tr_t.push_back(t);
      if (busy) res_busy++;
      if (done) res_dones++;
      if (!bus.cmd_ready) res_ready_low++;
      if (enc_a && !prev[1]) begin
        res_edges++;
        res_dec += enc_b ? 1 : -1;
      end
      if ((prev ^ {enc_a, enc_b}) == 2'b11) res_glitch++;
      prev = {enc_a, enc_b};
      if (done) break;
      if (abort_k >= 0 && res_abort_t < 0 && t / P == abort_k) begin
        bus.abort = 1'b1;
        res_abort_t = t;
      end
      en = (c % en_per == en_per - 1);
      if (en) t++;
    end
    en = 1'b1;
  endtask
  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_count = '0; bus.abort = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_dir = 1'b0; bus1.cmd_count = '0; bus1.abort = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, enc_a, enc_b, bus.cmd_ready, busy1, done1, enc_a1, enc_b1, bus1.cmd_ready} !== 10'b0000100001)
      $display("FAIL reset_state: got %b expected 0000100001", {busy, done, enc_a, enc_b, bus.cmd_ready, busy1, done1, enc_a1, enc_b1, bus1.cmd_ready});
    else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, enc_a, enc_b, bus.cmd_ready} !== 5'b00001)
      $display("FAIL idle_after_reset: got %b expected 00001", {busy, done, enc_a, enc_b, bus.cmd_ready});
    else n_pass++;
  endtask
  task automatic test_up();
    int bad = -1;
    run(1'b1, 3, 1, -1, 60);
    foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(1'b1, tr_t[i], 3)) bad = i;
    n_chk++;
    if (bad >= 0) $display("FAIL up_seq: sample %0d got %b expected %b", bad, tr_obs[bad], model_obs(1'b1, tr_t[bad], 3));
    else n_pass++;
    n_chk++;
    if (res_busy !== 48) $display("FAIL up_busy_len: got %0d expected 48", res_busy); else n_pass++;
    n_chk++;
    if (res_dones !== 1) $display("FAIL up_done_count: got %0d expected 1", res_dones); else n_pass++;
    n_chk++;
    if (res_dec !== 3) $display("FAIL up_decoder: got %0d expected 3", res_dec); else n_pass++;
    n_chk++;
    if (res_glitch !== 0) $display("FAIL up_gray: got %0d double changes expected 0", res_glitch); else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_down_slow();
    int bad = -1;
    run(1'b0, 2, 3, -1, 110);
    foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(1'b0, tr_t[i], 2)) bad = i;
    n_chk++;
    if (bad >= 0) $display("FAIL down_seq: sample %0d got %b expected %b", bad, tr_obs[bad], model_obs(1'b0, tr_t[bad], 2));
    else n_pass++;
    n_chk++;
    if (res_edges !== 2 || res_dec !== -2) $display("FAIL down_decoder: got edges %0d count %0d expected 2 and -2", res_edges, res_dec);
    else n_pass++;
    n_chk++;
    if (res_busy !== 96) $display("FAIL down_busy_len: got %0d expected 96", res_busy); else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_abort();
    int bad = -1;
    int n_eff;
    run(1'b1, 10, 1, 5, 200);
    n_eff = (res_abort_t < 0) ? 10 : res_abort_t / (4 * P) + 1;
    foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(1'b1, tr_t[i], n_eff)) bad = i;
    n_chk++;
    if (bad >= 0) $display("FAIL abort_seq: sample %0d got %b expected %b", bad, tr_obs[bad], model_obs(1'b1, tr_t[bad], n_eff));
    else n_pass++;
    n_chk++;
    if (res_edges !== 2) $display("FAIL abort_edges: got %0d expected 2", res_edges); else n_pass++;
    n_chk++;
    if (res_dones !== 1 || res_glitch !== 0) $display("FAIL abort_done: got dones %0d glitches %0d expected 1 and 0", res_dones, res_glitch);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_abort_idle();
    int bad = -1;
    run(1'b0, 1, 1, -2, 30);
    foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(1'b0, tr_t[i], 1)) bad = i;
    n_chk++;
    if (bad >= 0) $display("FAIL abort_idle_seq: sample %0d got %b expected %b", bad, tr_obs[bad], model_obs(1'b0, tr_t[bad], 1));
    else n_pass++;
    n_chk++;
    if (res_edges !== 1 || res_dones !== 1) $display("FAIL abort_idle_edges: got edges %0d dones %0d expected 1 and 1", res_edges, res_dones);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_zero_back_to_back();
    int bad = -1;
    run(1'b1, 0, 1, -1, 5);
    n_chk++;
    if (tr_obs.size() !== 1 || tr_obs[0] !== 4'b0100)
      $display("FAIL zero_done: got %0d samples first %b expected 1 sample 0100", tr_obs.size(), tr_obs[0]);
    else n_pass++;
    n_chk++;
    if (res_ready_low !== 0 || res_busy !== 0) $display("FAIL zero_ready: got ready-low %0d busy %0d expected 0 and 0", res_ready_low, res_busy);
    else n_pass++;
    run(1'b1, 1, 1, -1, 30);
    foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(1'b1, tr_t[i], 1)) bad = i;
    n_chk++;
    if (bad >= 0) $display("FAIL b2b_seq: sample %0d got %b expected %b", bad, tr_obs[bad], model_obs(1'b1, tr_t[bad], 1));
    else n_pass++;
    n_chk++;
    if (res_edges !== 1 || res_dones !== 1) $display("FAIL b2b_edges: got edges %0d dones %0d expected 1 and 1", res_edges, res_dones);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int bad = -1;
    int acc = 0;
    bus.cmd_valid = 1'b1; bus.cmd_dir = 1'b1; bus.cmd_count = CW'(5); en = 1'b1;
    @(negedge clk);
    bus.cmd_dir = 1'b0;
    bus.cmd_count = CW'(7);
    for (int t = 0; t < 6; t++) begin
      if (bad < 0 && {busy, done, enc_a, enc_b} !== model_obs(1'b1, t, 5)) bad = t;
      if (bus.cmd_ready) acc++;
      if (t < 5) @(negedge clk);
    end
    n_chk++;
    if (bad >= 0) $display("FAIL run_ignores_cmd_seq: tick %0d got %b expected %b", bad, {busy, done, enc_a, enc_b}, model_obs(1'b1, bad, 5));
    else n_pass++;
    n_chk++;
    if (acc !== 0) $display("FAIL run_ready: got ready high %0d cycles expected 0", acc); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, done, enc_a, enc_b, bus.cmd_ready} !== 5'b00001)
      $display("FAIL reset_mid: got %b expected 00001", {busy, done, enc_a, enc_b, bus.cmd_ready});
    else n_pass++;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      logic d = 1'($urandom_range(0, 1));
      int n = $urandom_range(1, 4);
      int ep = $urandom_range(1, 3);
      int bad = -1;
      run(d, n, ep, -1, 4 * n * P * ep + 10);
      foreach (tr_obs[i]) if (bad < 0 && tr_obs[i] !== model_obs(d, tr_t[i], n)) bad = i;
      n_chk++;
      if (bad >= 0) $display("FAIL rand_seq dir=%0d n=%0d en_per=%0d: sample %0d got %b expected %b", d, n, ep, bad, tr_obs[bad], model_obs(d, tr_t[bad], n));
      else n_pass++;
      n_chk++;
      if (res_dec !== (d ? n : -n)) $display("FAIL rand_decoder dir=%0d n=%0d: got %0d expected %0d", d, n, res_dec, d ? n : -n);
      else n_pass++;
      repeat (2) @(negedge clk);
    end
  endtask
  task automatic test_max_count();
    int nb = 0;
    int ne = 0;
    int nd = 0;
    int dec = 0;
    logic pa = 1'b0;
    bit fin = 1'b0;
    bus1.cmd_valid = 1'b1; bus1.cmd_dir = 1'b1; bus1.cmd_count = CW'(255);
    for (int c = 0; c < 1100 && !fin; c++) begin
      @(negedge clk);
      bus1.cmd_valid = 1'b0;
      if (busy1) nb++;
      if (enc_a1 && !pa) begin
        ne++;
        dec += enc_b1 ? 1 : -1;
      end
      pa = enc_a1;
      if (done1) begin
        nd++;
        fin = 1'b1;
      end
    end
    n_chk++;
    if (nb !== 1020) $display("FAIL max_busy_len: got %0d expected 1020", nb); else n_pass++;
    n_chk++;
    if (ne !== 255 || dec !== 255) $display("FAIL max_edges: got edges %0d count %0d expected 255 and 255", ne, dec);
    else n_pass++;
    n_chk++;
    if (nd !== 1) $display("FAIL max_done: got %0d expected 1", nd); else n_pass++;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({busy1, done1, enc_a1, enc_b1, bus1.cmd_ready} !== 5'b00001)
      $display("FAIL max_idle_after: got %b expected 00001", {busy1, done1, enc_a1, enc_b1, bus1.cmd_ready});
    else n_pass++;
  endtask
  initial begin
    test_reset();
    test_up();
    test_down_slow();
    test_abort();
    test_abort_idle();
    test_zero_back_to_back();
    test_reset_mid();
    test_random();
    test_max_count();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
